// File: rtl/ssd_bcd_scanner_if.sv
// ---------------------------------------------------------------------------
// ssd_bcd_scanner_if
// Bundles the value/load request and the display-side results of
// ssd_bcd_scanner into one port.
//   value_in [DATA_W] : binary value to convert (master -> slave)
//   load              : single-cycle convert request (master -> slave)
//   busy              : conversion in progress, load ignored (slave -> master)
//   bcd      [16]     : committed digits {thousands,hundreds,tens,ones}
//   anode    [4]      : active-low digit enable, one-hot-low
//   segments [7]      : active-low {a,b,c,d,e,f,g}
// ---------------------------------------------------------------------------
interface ssd_bcd_scanner_if #(
    parameter int unsigned DATA_W = 13
);
    logic [DATA_W-1:0] value_in;
    logic              load;
    logic              busy;
    logic [15:0]       bcd;
    logic [3:0]        anode;
    logic [6:0]        segments;

    modport master (
        output value_in, load,
        input  busy, bcd, anode, segments
    );

    modport slave (
        input  value_in, load,
        output busy, bcd, anode, segments
    );
endinterface

// File: rtl/ssd_bcd_scanner.sv
// ---------------------------------------------------------------------------
// ssd_bcd_scanner
// Converts an unsigned binary value to four BCD digits with a sequential
// shift-add-3 engine (one bit per cycle) and time-multiplexes the committed
// digits onto a 4-anode 7-segment display.
//   clk  : display clock
//   rst  : synchronous, active-high reset
//   bus  : ssd_bcd_scanner_if.slave (value_in, load, busy, bcd, anode,
//          segments)
// Parameters:
//   DATA_W      : binary input width, 1..13
//   REFRESH_DIV : clock cycles each digit is held, >= 2
// Optional feature macro:
//   SSD_BLANK_ZERO_EN : blank leading zero digits (index 0 never blanked)
// ---------------------------------------------------------------------------
module ssd_bcd_scanner #(
    parameter int unsigned DATA_W      = 13,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    ssd_bcd_scanner_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_COMMIT
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_W-1:0]  r_shift;
    logic [15:0]        r_scratch;
    logic [CNT_W-1:0]   r_cnt;
    logic [15:0]        r_bcd;
    logic [REF_W-1:0]   r_ref;
    logic [1:0]         r_idx;

    logic               w_busy;
    logic               w_capture;
    logic               w_shift;
    logic               w_commit;
    logic               w_last_bit;
    logic [15:0]        w_adj;
    logic [DATA_W+15:0] w_cat;
    logic [3:0]         w_digit;
    logic               w_blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_last_bit = (r_cnt == CNT_W'(DATA_W - 1));

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (bus.load) w_state_nxt = S_CONVERT;
            S_CONVERT: if (w_last_bit) w_state_nxt = S_COMMIT;
            S_COMMIT:  w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs / datapath controls ----------------
    always_comb begin
        w_busy    = 1'b0;
        w_capture = 1'b0;
        w_shift   = 1'b0;
        w_commit  = 1'b0;
        case (r_state)
            S_IDLE:    w_capture = bus.load;
            S_CONVERT: begin
                w_busy  = 1'b1;
                w_shift = 1'b1;
            end
            S_COMMIT:  begin
                w_busy   = 1'b1;
                w_commit = 1'b1;
            end
            default:   w_busy = 1'b0;
        endcase
    end

    // Add-3 correction on every nibble, then shift {scratch, shift} left
    // as one wide register so the input MSB enters the ones nibble.
    always_comb begin
        w_adj = r_scratch;
        for (int unsigned i = 0; i < 4; i++) begin
            if (r_scratch[i*4 +: 4] >= 4'd5) begin
                w_adj[i*4 +: 4] = r_scratch[i*4 +: 4] + 4'd3;
            end
        end
        w_cat = {w_adj, r_shift} << 1;
    end

    // ---------------- Conversion datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_bcd     <= '0;
        end else begin
            if (w_capture) begin
                r_shift   <= bus.value_in;
                r_scratch <= '0;
                r_cnt     <= '0;
            end else if (w_shift) begin
                r_scratch <= w_cat[DATA_W+15:DATA_W];
                r_shift   <= w_cat[DATA_W-1:0];
                r_cnt     <= r_cnt + CNT_W'(1);
            end
            if (w_commit) begin
                r_bcd <= r_scratch;
            end
        end
    end

    // ---------------- Refresh scan ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref <= '0;
            r_idx <= '0;
        end else if (r_ref == REF_W'(REFRESH_DIV - 1)) begin
            r_ref <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_ref <= r_ref + REF_W'(1);
        end
    end

    // ---------------- Display decode ----------------
    always_comb begin
        w_digit = r_bcd[r_idx*4 +: 4];
`ifdef SSD_BLANK_ZERO_EN
        // Blank a digit only when it and every higher digit are zero.
        case (r_idx)
            2'd3:    w_blank = (r_bcd[15:12] == 4'd0);
            2'd2:    w_blank = (r_bcd[15:8]  == 8'd0);
            2'd1:    w_blank = (r_bcd[15:4]  == 12'd0);
            default: w_blank = 1'b0;
        endcase
`else
        w_blank = 1'b0;
`endif
    end

    assign bus.busy     = w_busy;
    assign bus.bcd      = r_bcd;
    assign bus.anode    = ~(4'b0001 << r_idx);
    assign bus.segments = w_blank ? 7'b1111111 : seg_decode(w_digit);

endmodule

// File: tb/tb_ssd_bcd_scanner.sv
// ---------------------------------------------------------------------------
// tb_ssd_bcd_scanner
// Directed bench for ssd_bcd_scanner with DATA_W=13, REFRESH_DIV=4.
// Expected digits, glyphs, latencies and scan positions are hand-derived.
// ---------------------------------------------------------------------------
module tb_ssd_bcd_scanner;

    localparam int unsigned DW  = 13;
    localparam int unsigned DIV = 4;

    logic clk;
    logic rst;

    ssd_bcd_scanner_if #(.DATA_W(DW)) bus ();

    ssd_bcd_scanner #(
        .DATA_W      (DW),
        .REFRESH_DIV (DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;   // edges since last reset edge -> expected scan position

    logic [6:0] seg_tab [0:9];
    logic [3:0] an_tab  [0:3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) cyc = 0;
        else     cyc = cyc + 1;
        #1;
    endtask

    function automatic int exp_idx();
        return (cyc / DIV) % 4;
    endfunction

    task automatic wait_idx(input int k);
        for (int i = 0; i < 4 * DIV + 1; i++) begin
            if (exp_idx() == k) break;
            tick();
        end
    endtask

    // Load a value, check exact busy duration and committed digits.
    task automatic do_load(input string tag, input logic [DW-1:0] v, input logic [15:0] exp_bcd);
        int n;
        bus.value_in = v;
        bus.load     = 1'b1;
        tick();
        bus.load     = 1'b0;
        check({tag, "_busy_hi"}, 32'(bus.busy), 32'd1);
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, DW + 1);
        check({tag, "_bcd"}, 32'(bus.bcd), 32'(exp_bcd));
    endtask

    // Walk the four scan positions and compare anode and glyph at each.
    task automatic check_digits(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                                input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] exp_s [0:3];
        exp_s[0] = s0; exp_s[1] = s1; exp_s[2] = s2; exp_s[3] = s3;
        for (int k = 0; k < 4; k++) begin
            wait_idx(k);
            check($sformatf("%s_an%0d", tag, k), 32'(bus.anode), 32'(an_tab[k]));
            check($sformatf("%s_seg%0d", tag, k), 32'(bus.segments), 32'(exp_s[k]));
        end
    endtask

    initial begin
        logic [6:0] blank;
        seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111; seg_tab[2] = 7'b0010010;
        seg_tab[3] = 7'b0000110; seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
        seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0000100;
        an_tab[0] = 4'b1110; an_tab[1] = 4'b1101; an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;
`ifdef SSD_BLANK_ZERO_EN
        blank = 7'b1111111;
`else
        blank = 7'b0000001;
`endif

        rst          = 1'b1;
        bus.load     = 1'b0;
        bus.value_in = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_bcd", 32'(bus.bcd), 32'h0);
        check("rst_anode", 32'(bus.anode), 32'b1110);
        check("rst_seg", 32'(bus.segments), 32'b0000001);

        // Idle scan: one full frame plus wrap back to digit 0
        for (int i = 0; i <= 4 * DIV; i++) begin
            check($sformatf("idle_an_c%0d", i), 32'(bus.anode), 32'(an_tab[exp_idx()]));
            check($sformatf("idle_seg_c%0d", i), 32'(bus.segments), 32'b0000001);
            if (i < 4 * DIV) tick();
        end
        check("idle_bcd", 32'(bus.bcd), 32'h0);

        // 1234: busy throughout, then committed; all four glyphs
        do_load("v1234", 13'd1234, 16'h1234);
        check_digits("g1234", seg_tab[4], seg_tab[3], seg_tab[2], seg_tab[1]);

        // Extremes
        do_load("v8191", 13'd8191, 16'h8191);
        do_load("v0", 13'd0, 16'h0000);

        // Load during conversion is dropped
        bus.value_in = 13'd1234;
        bus.load     = 1'b1;
        tick();                                   // edge T
        bus.load     = 1'b0;
        tick(); tick();                           // T+1, T+2
        bus.value_in = 13'd4321;
        bus.load     = 1'b1;
        tick();                                   // T+3
        bus.load     = 1'b0;
        bus.value_in = 13'd0;
        for (int i = 4; i < 14; i++) tick();      // through T+13
        check("drop_busy_T13", 32'(bus.busy), 32'd1);
        check("drop_bcd_T13", 32'(bus.bcd), 32'h0000);
        tick();                                   // T+14
        check("drop_busy_T14", 32'(bus.busy), 32'd0);
        check("drop_bcd_T14", 32'(bus.bcd), 32'h1234);
        for (int i = 0; i < 20; i++) tick();
        check("drop_no_requeue", 32'(bus.bcd), 32'h1234);

        // Reset mid-conversion (5555 loaded at T, rst at T+7)
        bus.value_in = 13'd5555;
        bus.load     = 1'b1;
        tick();
        bus.load     = 1'b0;
        for (int i = 1; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_bcd", 32'(bus.bcd), 32'h0000);
        check("midrst_anode", 32'(bus.anode), 32'b1110);
        for (int i = 0; i < 20; i++) tick();
        check("midrst_stays0", 32'(bus.bcd), 32'h0000);

        // Reset and load together: reset wins
        bus.value_in = 13'd77;
        bus.load     = 1'b1;
        rst          = 1'b1;
        tick();
        rst          = 1'b0;
        bus.load     = 1'b0;
        check("rstload_busy", 32'(bus.busy), 32'd0);

        // 42: leading-zero display behaviour
        do_load("v42", 13'd42, 16'h0042);
        check_digits("g42", seg_tab[2], seg_tab[4], blank, blank);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
